// File: rtl/bcd_adder_pkg.sv
// Shared types and constants for the BCD operand adder.
package bcd_adder_pkg;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    ADD    = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam int DIGIT_W         = 4;
  localparam int BCD_MAX         = 9;
  localparam int BCD_CORR_THRESH = 10;

endpackage

// File: rtl/btn_conditioner.sv
// Load button conditioning: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Debounce filter is built only when BCD_ADDER_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BCD_ADDER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // The filtered level flips on the cycle the disagreement count reaches DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt  <= '0;
      r_filt <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign pulse_o = w_level & ~r_prev;

endmodule

// File: rtl/bcd_operand_adder.sv
// Two-operand BCD adder sequenced by a load button; presents a two-digit BCD sum.
// Optional button debounce: define BCD_ADDER_DEBOUNCE_EN.
module bcd_operand_adder
  import bcd_adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               load_btn,
  input  logic               clr,
  output logic [DIGIT_W-1:0] sum_tens,
  output logic [DIGIT_W-1:0] sum_units,
  output logic               sum_valid,
  output logic               err,
  output logic [1:0]         state_o
);

  state_t             r_state, w_state_nxt;
  logic [DIGIT_W-1:0] r_op_a, w_op_a_nxt;
  logic [DIGIT_W-1:0] r_op_b, w_op_b_nxt;
  logic [DIGIT_W-1:0] r_tens, w_tens_nxt;
  logic [DIGIT_W-1:0] r_units, w_units_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_err, w_err_nxt;
  logic               w_load_pulse;
  logic               w_digit_ok;
  logic [4:0]         w_sum;
  logic [4:0]         w_sum_corr;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (load_btn),
    .pulse_o(w_load_pulse)
  );

  assign w_digit_ok = (digit_i <= DIGIT_W'(BCD_MAX));
  assign w_sum      = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign w_sum_corr = w_sum - 5'(BCD_CORR_THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_A;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_tens  <= '0;
      r_units <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_tens  <= w_tens_nxt;
      r_units <= w_units_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    if (clr) begin
      // A load in the same cycle as clr is dropped, not deferred.
      w_state_nxt = WAIT_A;
      w_op_a_nxt  = '0;
      w_op_b_nxt  = '0;
      w_tens_nxt  = '0;
      w_units_nxt = '0;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        WAIT_A, SHOW: begin
          if (w_load_pulse) begin
            w_valid_nxt = 1'b0;
            w_tens_nxt  = '0;
            w_units_nxt = '0;
            if (w_digit_ok) begin
              w_op_a_nxt  = digit_i;
              w_err_nxt   = 1'b0;
              w_state_nxt = WAIT_B;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = WAIT_A;
            end
          end
        end
        WAIT_B: begin
          if (w_load_pulse) begin
            if (w_digit_ok) begin
              w_op_b_nxt  = digit_i;
              w_err_nxt   = 1'b0;
              w_state_nxt = ADD;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        ADD: begin
          if (w_sum >= 5'(BCD_CORR_THRESH)) begin
            w_tens_nxt  = DIGIT_W'(1);
            w_units_nxt = w_sum_corr[DIGIT_W-1:0];
          end else begin
            w_tens_nxt  = '0;
            w_units_nxt = w_sum[DIGIT_W-1:0];
          end
          w_valid_nxt = 1'b1;
          w_state_nxt = SHOW;
        end
        default: w_state_nxt = WAIT_A;
      endcase
    end
  end

  assign sum_tens  = r_tens;
  assign sum_units = r_units;
  assign sum_valid = r_valid;
  assign err       = r_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_bcd_operand_adder.sv
// Bench for bcd_operand_adder: directed cases plus random presses against a scoreboard.
module tb_bcd_operand_adder;

`ifdef BCD_ADDER_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_i = 4'd0;
  logic       load_btn = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] sum_tens;
  logic [3:0] sum_units;
  logic       sum_valid;
  logic       err;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];

  // model: phase 0 = waiting A, 1 = waiting B, 2 = showing a result
  int m_phase = 0;
  int m_a = 0;
  int m_err = 0;

  bcd_operand_adder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .digit_i  (digit_i),
    .load_btn (load_btn),
    .clr      (clr),
    .sum_tens (sum_tens),
    .sum_units(sum_units),
    .sum_valid(sum_valid),
    .err      (err),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_a = 0;
    m_err = 0;
  endtask

  task automatic model_press(input int d);
    if (m_phase == 1) begin
      if (d <= 9) begin
        exp_q.push_back({4'((m_a + d) / 10), 4'((m_a + d) % 10)});
        m_phase = 2;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      if (d <= 9) begin
        m_a = d;
        m_phase = 1;
        m_err = 0;
      end else begin
        m_err = 1;
        m_phase = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, int'(state_o), (m_phase == 2) ? 3 : m_phase);
    check({tag, "_err"}, int'(err), m_err);
    check({tag, "_valid"}, int'(sum_valid), (m_phase == 2) ? 1 : 0);
    if (m_phase != 2)
      check({tag, "_sum_zero"}, int'({sum_tens, sum_units}), 0);
  endtask

  task automatic press(input int d, input int hold);
    model_press(d);
    @(negedge clk);
    digit_i = 4'(d);
    load_btn = 1'b1;
    repeat (hold) @(negedge clk);
    load_btn = 1'b0;
    repeat (4 + 2 * DB) @(negedge clk);
  endtask

  // monitor: every new result is popped and compared
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (sum_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got sum %0d%0d, expected no result", sum_tens, sum_units);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_tens", int'(sum_tens), int'(e[7:4]));
        check("sb_units", int'(sum_units), int'(e[3:0]));
      end
    end
    prev_valid = sum_valid;
  end

  initial begin
    int d;
    #1;
    check("rst_state", int'(state_o), 0);
    check("rst_outputs", int'({sum_tens, sum_units, sum_valid, err}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // first-capture latency and sum_valid timing: 3 + 4 = 7
    model_press(3);
    @(negedge clk);
    digit_i = 4'd3;
    load_btn = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 check("lat_before_capture", int'(state_o), 0);
    @(posedge clk);
    #1 check("lat_at_capture", int'(state_o), 1);
    @(negedge clk);
    load_btn = 1'b0;
    repeat (4 + 2 * DB) @(negedge clk);
    model_press(4);
    digit_i = 4'd4;
    load_btn = 1'b1;
    repeat (LAT) @(posedge clk);
    #1 check("add_state", int'(state_o), 2);
    check("add_valid_low", int'(sum_valid), 0);
    @(posedge clk);
    #1 check("show_state", int'(state_o), 3);
    check("show_valid", int'(sum_valid), 1);
    @(negedge clk);
    load_btn = 1'b0;
    repeat (4 + 2 * DB) @(negedge clk);
    check_model("t2");

    // carry boundaries
    press(9, 2 + DB); press(9, 2 + DB); check_model("t3a");
    press(5, 2 + DB); press(5, 2 + DB); check_model("t3b");
    press(0, 2 + DB); press(0, 2 + DB); check_model("t3c");

    // invalid digit rejected in WAIT_A (the SHOW press leaves it there), then accepted
    press(12, 2 + DB); check_model("t4_bad");
    press(5, 2 + DB);  check_model("t4_good");
    press(15, 2 + DB); check_model("t4_bad_b");

    // clr coincident with the load pulse in WAIT_B; held button gives no second load
    @(negedge clk);
    digit_i = 4'd6;
    load_btn = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 check("clr_state", int'(state_o), 0);
    check("clr_valid", int'(sum_valid), 0);
    check("clr_err", int'(err), 0);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    check("clr_no_deferred", int'(state_o), 0);
    load_btn = 1'b0;
    repeat (4 + 2 * DB) @(negedge clk);
    press(2, 20);
    check_model("held_one_capture");

    // reset mid-sequence in WAIT_B with opA = 7
    press(7, 2 + DB);
    press(7, 2 + DB);
    check_model("pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_state", int'(state_o), 0);
    check("async_rst_outputs", int'({sum_tens, sum_units, sum_valid, err}), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    check("post_rst_idle", int'(state_o), 0);
    press(8, 2 + DB);
    check_model("post_rst_load");

`ifdef BCD_ADDER_DEBOUNCE_EN
    // short glitch must be filtered out
    @(negedge clk);
    digit_i = 4'd1;
    load_btn = 1'b1;
    repeat (2) @(negedge clk);
    load_btn = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_ignored", int'(state_o), 1);
    press(1, 10);
    check_model("debounced_load");
`endif

    // random presses, biased toward valid digits
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      press(d, $urandom_range(1 + DB, 6 + DB));
      check_model("rand");
    end

    repeat (5) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
